// File: rtl/sysid_probe_master_if.sv
// Avalon-MM read-only bus between the system-ID probe master and its responder.
interface sysid_probe_master_if;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address, avm_read,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/sysid_probe_master.sv
// Reads the system-ID word and build timestamp over Avalon-MM and flags whether
// they match the values this image was built against, with a per-read timeout.
module sysid_probe_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1490707641,
  parameter logic [31:0] BASE_ADDR          = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES     = 1024,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 id_ok,
  output logic                 ts_ok,
  output logic                 timeout,
  output logic [31:0]          id_value,
  output logic [31:0]          ts_value,
  sysid_probe_master_if.master avm
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ID, S_WAIT_ID, S_RD_TS, S_WAIT_TS, S_DONE
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_next;
  logic [15:0] r_cnt;
  logic        r_auto, r_done, r_id_ok, r_ts_ok, r_timeout;
  logic [31:0] r_id_value, r_ts_value;
  logic        w_busy, w_read;
  logic [31:0] w_addr;
  logic        w_accept, w_cap_id, w_cap_ts, w_tmo, w_launch;

  // Zero-latency responders return data in the acceptance cycle itself.
  assign w_accept = w_read && !avm.avm_waitrequest;
  assign w_cap_id = avm.avm_readdatavalid &&
                    ((r_state == S_RD_ID && w_accept) || r_state == S_WAIT_ID);
  assign w_cap_ts = avm.avm_readdatavalid &&
                    ((r_state == S_RD_TS && w_accept) || r_state == S_WAIT_TS);
  assign w_tmo    = w_busy && (r_cnt == TMO_LAST) && !w_cap_id && !w_cap_ts;
  assign w_launch = (r_state == S_IDLE) && (start || r_auto);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_launch) w_next = S_RD_ID;
      S_RD_ID:   if (w_cap_id) w_next = S_RD_TS;
                 else if (w_tmo) w_next = S_DONE;
                 else if (w_accept) w_next = S_WAIT_ID;
      S_WAIT_ID: if (w_cap_id) w_next = S_RD_TS;
                 else if (w_tmo) w_next = S_DONE;
      S_RD_TS:   if (w_cap_ts || w_tmo) w_next = S_DONE;
                 else if (w_accept) w_next = S_WAIT_TS;
      S_WAIT_TS: if (w_cap_ts || w_tmo) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_read = 1'b0;
    w_addr = '0;
    unique case (r_state)
      S_RD_ID:   begin w_busy = 1'b1; w_read = 1'b1; w_addr = BASE_ADDR; end
      S_WAIT_ID: w_busy = 1'b1;
      S_RD_TS:   begin w_busy = 1'b1; w_read = 1'b1; w_addr = BASE_ADDR + 32'd4; end
      S_WAIT_TS: w_busy = 1'b1;
      default:   ;
    endcase
  end

  // Counter restarts on entry to each read phase so each word gets a full budget.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_cnt <= '0;
    else if ((w_next == S_RD_ID || w_next == S_RD_TS) && w_next != r_state)
      r_cnt <= '0;
    else if (w_busy)
      r_cnt <= r_cnt + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_auto     <= AUTO_START;
      r_done     <= 1'b0;
      r_id_ok    <= 1'b0;
      r_ts_ok    <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_value <= '0;
      r_ts_value <= '0;
    end else begin
      if (w_launch) begin
        r_auto    <= 1'b0;
        r_done    <= 1'b0;
        r_id_ok   <= 1'b0;
        r_ts_ok   <= 1'b0;
        r_timeout <= 1'b0;
      end
      if (w_cap_id) begin
        r_id_value <= avm.avm_readdata;
        r_id_ok    <= (avm.avm_readdata == EXPECTED_ID);
      end
      if (w_cap_ts) begin
        r_ts_value <= avm.avm_readdata;
        r_ts_ok    <= (avm.avm_readdata == EXPECTED_TIMESTAMP);
      end
      if (w_tmo)            r_timeout <= 1'b1;
      if (w_next == S_DONE) r_done    <= 1'b1;
    end
  end

  assign busy            = w_busy;
  assign done            = r_done;
  assign id_ok           = r_id_ok;
  assign ts_ok           = r_ts_ok;
  assign timeout         = r_timeout;
  assign id_value        = r_id_value;
  assign ts_value        = r_ts_value;
  assign avm.avm_read    = w_read;
  assign avm.avm_address = w_addr;

endmodule
